// File: rtl/decode_q.sv
// decode_q: instruction alignment buffer and decode-output register.
//
// Fetch words of four 16-bit parcels are pushed into a circular parcel buffer.
// The instruction at the head is sized from its first parcel (1, 2 or 4 parcels).
// Once the whole instruction is buffered it is left-justified into a 64-bit raw
// word, canonicalised and checked for a bad opcode. Its fields and read-port
// register numbers are then captured into a registered valid/ready output stage.
//
// Parameters
//   BUF_PARCELS  buffer depth in 16-bit parcels (power of two, >= 8)
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   drop all buffered parcels and any pending decode
//   fetch_valid/fetch_data  fetch word; [63:48] is first in program order
//   fetch_ready             buffer has room for a full fetch word
//   dec_valid/dec_ready     decoded-instruction handshake
//   inst_type/unit/op       canonical bits [61], [60:58], [57:56]
//   rs1_rn/rs2_rn/rd_rn/rd2_rn  canonical [43:38], [37:32], [55:50], [49:44]
//   imm_data                canonical [55:0], zero-extended
//   r1_rn/r2_rn             register numbers to read, 0 when unused
//   inst_len                0=16b, 1=32b, 2=64b
//   bad_opcode              bad-opcode flag for the decoded instruction
module decode_q #(
  parameter int BUF_PARCELS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [63:0] fetch_data,
  output logic        fetch_ready,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic        inst_type,
  output logic [2:0]  unit,
  output logic [1:0]  op,
  output logic [5:0]  rs1_rn,
  output logic [5:0]  rs2_rn,
  output logic [5:0]  rd_rn,
  output logic [5:0]  rd2_rn,
  output logic [56:0] imm_data,
  output logic [5:0]  r1_rn,
  output logic [5:0]  r2_rn,
  output logic [1:0]  inst_len,
  output logic        bad_opcode
);

  localparam int PTR_W = $clog2(BUF_PARCELS);
  localparam int CNT_W = PTR_W + 1;

  // The raw encoding is already in canonical form.
  function automatic logic [63:0] de_canonicalize(input logic [63:0] rawInst);
    return rawInst;
  endfunction

  // The opcode map currently has no illegal encodings; the word is reduced so
  // the check stays tied to the instruction it judges.
  function automatic logic de_badDetect(input logic [63:0] rawInst);
    return 1'b0 & (^rawInst);
  endfunction

  logic [15:0]      pbuf_q [BUF_PARCELS];
  logic [PTR_W-1:0] head_q, head_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dec_valid_q, dec_valid_d;

  logic             inst_type_q;
  logic [2:0]       unit_q;
  logic [1:0]       op_q;
  logic [5:0]       rs1_q, rs2_q, rd_q, rd2_q, r1_q, r2_q;
  logic [56:0]      imm_q;
  logic [1:0]       len_q;
  logic             bad_q;

  logic             accept, load, avail;
  logic [2:0]       headLen;
  logic [PTR_W-1:0] wrBase;
  logic [15:0]      p0, p1, p2, p3;
  logic [63:0]      raw, canon;
  logic             useRs1Rs2, useRs1Only, useRs1Rd;
  logic [5:0]       r1_d, r2_d;
  logic [1:0]       lenCode;

  // fetch_ready looks only at the registered count, so a word is accepted only
  // when four free slots exist regardless of what decode consumes this cycle.
  assign fetch_ready = (count_q <= CNT_W'(BUF_PARCELS - 4));
  assign accept      = fetch_valid & fetch_ready & ~flush;
  assign wrBase      = head_q + count_q[PTR_W-1:0];

  assign p0 = pbuf_q[head_q];
  assign p1 = pbuf_q[head_q + PTR_W'(1)];
  assign p2 = pbuf_q[head_q + PTR_W'(2)];
  assign p3 = pbuf_q[head_q + PTR_W'(3)];

  always_comb begin
    headLen = 3'd1;
    if (p0[15]) headLen = p0[14] ? 3'd4 : 3'd2;
  end

  assign avail = (count_q >= CNT_W'(headLen));
  assign load  = avail & (~dec_valid_q | dec_ready) & ~flush;

  always_comb begin
    raw = {p0, 48'h0};
    if (headLen != 3'd1) raw[47:32] = p1;
    if (headLen == 3'd4) raw[31:0]  = {p2, p3};
  end

  assign canon = de_canonicalize(raw);

  // Read-port selection from type/unit/op of the canonical word.
  assign useRs1Rs2  = ~canon[61] & ((canon[60:58] < 3'd5) |
                      ((canon[60:58] == 3'd7) & (canon[57:56] == 2'd1)));
  assign useRs1Only = (~canon[61] & (canon[60:58] == 3'd7) & canon[57]) |
                      (canon[61] & ((canon[60:58] < 3'd5) |
                      ((canon[60:58] == 3'd5) & (canon[57:56] != 2'd0))));
  assign useRs1Rd   = canon[61] & ((canon[60:58] == 3'd6) |
                      ((canon[60:58] == 3'd7) & ~canon[57]));

  assign r1_d = (useRs1Rs2 | useRs1Only | useRs1Rd) ? canon[43:38] : 6'd0;
  assign r2_d = useRs1Rd ? canon[55:50] : (useRs1Rs2 ? canon[37:32] : 6'd0);

  assign lenCode = canon[63] ? (canon[62] ? 2'd2 : 2'd1) : 2'd0;

  // Write slots start at head+count; accept is only possible with count <= N-4,
  // so the new parcels never overlap the ones being consumed.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 4; k++) begin
        pbuf_q[wrBase + PTR_W'(k)] <= fetch_data[63-16*k -: 16];
      end
    end
  end

  // Fill and drain can happen on the same edge; both are folded into count_d.
  always_comb begin
    head_d      = head_q;
    count_d     = count_q;
    dec_valid_d = dec_valid_q;
    if (flush) begin
      head_d      = '0;
      count_d     = '0;
      dec_valid_d = 1'b0;
    end else begin
      if (accept) count_d = count_d + CNT_W'(4);
      if (load) begin
        count_d     = count_d - CNT_W'(headLen);
        head_d      = head_q + PTR_W'(headLen);
        dec_valid_d = 1'b1;
      end else if (dec_valid_q && dec_ready) begin
        dec_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      count_q     <= '0;
      dec_valid_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      count_q     <= count_d;
      dec_valid_q <= dec_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_type_q <= 1'b0;
      unit_q      <= '0;
      op_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      len_q       <= '0;
      bad_q       <= 1'b0;
    end else if (load) begin
      inst_type_q <= canon[61];
      unit_q      <= canon[60:58];
      op_q        <= canon[57:56];
      rs1_q       <= canon[43:38];
      rs2_q       <= canon[37:32];
      rd_q        <= canon[55:50];
      rd2_q       <= canon[49:44];
      imm_q       <= {1'b0, canon[55:0]};
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      len_q       <= lenCode;
      bad_q       <= de_badDetect(raw);
    end
  end

  assign dec_valid  = dec_valid_q;
  assign inst_type  = inst_type_q;
  assign unit       = unit_q;
  assign op         = op_q;
  assign rs1_rn     = rs1_q;
  assign rs2_rn     = rs2_q;
  assign rd_rn      = rd_q;
  assign rd2_rn     = rd2_q;
  assign imm_data   = imm_q;
  assign r1_rn      = r1_q;
  assign r2_rn      = r2_q;
  assign inst_len   = len_q;
  assign bad_opcode = bad_q;

endmodule

// File: tb/tb_decode_q.sv
// tb_decode_q: scoreboard bench for decode_q.
// Two instances share the inputs: an 8-parcel buffer for the directed scenarios
// and a 16-parcel buffer for the random wrap-around stream. Instructions are
// turned into parcels and expected decode records when queued; the records are
// popped and compared whenever the selected instance hands off an instruction.
module tb_decode_q;

  typedef struct packed {
    logic        dv;
    logic        fr;
    logic        typ;
    logic [2:0]  unit;
    logic [1:0]  op;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rd;
    logic [5:0]  rd2;
    logic [56:0] imm;
    logic [5:0]  r1;
    logic [5:0]  r2;
    logic [1:0]  len;
    logic        bad;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, fetchValid, decReady;
  logic [63:0] fetchData;

  logic        aFr, aDv, aType, aBad, bFr, bDv, bType, bBad;
  logic [2:0]  aUnit, bUnit;
  logic [1:0]  aOp, aLen, bOp, bLen;
  logic [5:0]  aRs1, aRs2, aRd, aRd2, aR1, aR2;
  logic [5:0]  bRs1, bRs2, bRd, bRd2, bR1, bR2;
  logic [56:0] aImm, bImm;

  obs_t obs8, obs16;
  assign obs8  = {aDv, aFr, aType, aUnit, aOp, aRs1, aRs2, aRd, aRd2, aImm, aR1, aR2, aLen, aBad};
  assign obs16 = {bDv, bFr, bType, bUnit, bOp, bRs1, bRs2, bRd, bRd2, bImm, bR1, bR2, bLen, bBad};

  decode_q #(.BUF_PARCELS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fetch_valid(fetchValid), .fetch_data(fetchData), .fetch_ready(aFr),
    .dec_valid(aDv), .dec_ready(decReady),
    .inst_type(aType), .unit(aUnit), .op(aOp),
    .rs1_rn(aRs1), .rs2_rn(aRs2), .rd_rn(aRd), .rd2_rn(aRd2),
    .imm_data(aImm), .r1_rn(aR1), .r2_rn(aR2),
    .inst_len(aLen), .bad_opcode(aBad)
  );

  decode_q #(.BUF_PARCELS(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fetch_valid(fetchValid), .fetch_data(fetchData), .fetch_ready(bFr),
    .dec_valid(bDv), .dec_ready(decReady),
    .inst_type(bType), .unit(bUnit), .op(bOp),
    .rs1_rn(bRs1), .rs2_rn(bRs2), .rd_rn(bRd), .rd2_rn(bRd2),
    .imm_data(bImm), .r1_rn(bR1), .r2_rn(bR2),
    .inst_len(bLen), .bad_opcode(bBad)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          cycle = 0;
  bit          sel16 = 1'b0;
  bit          tAccepted, tFr;
  logic [15:0] parcelQ[$];
  obs_t        expQ[$];

  // Reference decode of a left-justified canonical word.
  function automatic obs_t model(input logic [63:0] c, input int lenP);
    obs_t m;
    logic t;
    logic [2:0] u;
    logic [1:0] o;
    bit rr, r1o, rdr;
    m = '0;
    t = c[61]; u = c[60:58]; o = c[57:56];
    rr  = !t && (u < 5 || (u == 7 && o == 1));
    r1o = (!t && u == 7 && o[1]) || (t && (u < 5 || (u == 5 && o != 0)));
    rdr = t && (u == 6 || (u == 7 && !o[1]));
    m.dv = 1'b1; m.typ = t; m.unit = u; m.op = o;
    m.rs1 = c[43:38]; m.rs2 = c[37:32]; m.rd = c[55:50]; m.rd2 = c[49:44];
    m.imm = {1'b0, c[55:0]};
    m.r1  = (rr || r1o || rdr) ? c[43:38] : 6'd0;
    m.r2  = rdr ? c[55:50] : (rr ? c[37:32] : 6'd0);
    m.len = (lenP == 1) ? 2'd0 : ((lenP == 2) ? 2'd1 : 2'd2);
    m.bad = 1'b0;
    return m;
  endfunction

  task automatic pushInst(input int lenP, input logic [63:0] bits);
    logic [63:0] raw;
    raw = bits;
    case (lenP)
      1:       begin raw[63] = 1'b0; raw[47:0] = '0; end
      2:       begin raw[63:62] = 2'b10; raw[31:0] = '0; end
      default: raw[63:62] = 2'b11;
    endcase
    for (int i = 0; i < lenP; i++) parcelQ.push_back(raw[63-16*i -: 16]);
    expQ.push_back(model(raw, lenP));
  endtask

  task automatic padWord;
    while (parcelQ.size() % 4 != 0) pushInst(1, 64'h0);
  endtask

  // One clock: drive a fetch word if allowed, record handshakes seen before the
  // edge, then step to 1 time unit past the edge.
  task automatic applyStimulus(input bit allowFetch, input bit rdy,
                               output bit popped, output obs_t got, output obs_t exp);
    obs_t cur;
    popped = 1'b0;
    tAccepted = 1'b0;
    decReady = rdy;
    fetchValid = allowFetch && (parcelQ.size() >= 4);
    if (fetchValid) fetchData = {parcelQ[0], parcelQ[1], parcelQ[2], parcelQ[3]};
    else            fetchData = {$urandom, $urandom};
    cur = sel16 ? obs16 : obs8;
    tFr = cur.fr;
    got = cur;
    got.fr = 1'b0;
    exp = '1;
    if (fetchValid && cur.fr) begin
      tAccepted = 1'b1;
      for (int k = 0; k < 4; k++) void'(parcelQ.pop_front());
    end
    if (cur.dv && rdy) begin
      popped = 1'b1;
      if (expQ.size() > 0) exp = expQ.pop_front();
    end
    @(posedge clk); #1;
    cycle++;
    fetchValid = 1'b0;
  endtask

  task automatic cleanState;
    flush = 1'b1; fetchValid = 1'b0; decReady = 1'b0;
    @(posedge clk); #1;
    cycle++;
    flush = 1'b0;
    parcelQ.delete();
    expQ.delete();
  endtask

  task automatic test_reset;
    obs_t rc;
    rc = '0; rc.fr = 1'b1;
    vectors++;
    if (obs8 !== rc) begin miscompares++; $display("[TB] FAIL reset8: got %h expected %h", obs8, rc); end
    vectors++;
    if (obs16 !== rc) begin miscompares++; $display("[TB] FAIL reset16: got %h expected %h", obs16, rc); end
  endtask

  task automatic test_four16;
    bit popped; obs_t got, exp; int acc, n;
    cleanState; sel16 = 1'b0; acc = -1; n = 0;
    for (int i = 0; i < 4; i++) pushInst(1, {$urandom, $urandom});
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b1, 1'b1, popped, got, exp);
      if (tAccepted && acc < 0) acc = c;
      if (popped) begin
        vectors++;
        if (got !== exp) begin miscompares++; $display("[TB] FAIL four16 data: got %h expected %h", got, exp); end
        vectors++;
        if (c !== acc + 2 + n) begin miscompares++; $display("[TB] FAIL four16 timing: got cycle %0d expected %0d", c, acc + 2 + n); end
        n++;
      end
    end
    vectors++;
    if (n !== 4) begin miscompares++; $display("[TB] FAIL four16 count: got %0d expected 4", n); end
    vectors++;
    if ({obs8.dv, obs8.fr} !== 2'b01) begin miscompares++; $display("[TB] FAIL four16 idle: got %b expected 01", {obs8.dv, obs8.fr}); end
  endtask

  task automatic test_split64;
    bit popped; obs_t got, exp; int n;
    cleanState; n = 0;
    pushInst(2, 64'h8000_1234_0000_0000);
    pushInst(4, 64'hC000_ABCD_1111_2222);
    pushInst(1, 64'h0001_0000_0000_0000);
    pushInst(1, 64'h0002_0000_0000_0000);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(c == 0, 1'b1, popped, got, exp);
      if (popped) begin
        vectors++;
        if (got !== exp) begin miscompares++; $display("[TB] FAIL split64 first: got %h expected %h", got, exp); end
        n++;
      end
    end
    vectors++;
    if (n !== 1 || obs8.dv !== 1'b0) begin miscompares++; $display("[TB] FAIL split64 early: got %0d/%b expected 1/0", n, obs8.dv); end
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 1'b1, popped, got, exp);
      if (popped) begin
        vectors++;
        if (got !== exp) begin miscompares++; $display("[TB] FAIL split64 rest: got %h expected %h", got, exp); end
        if (n == 1) begin
          vectors++;
          if (got.len !== 2'd2) begin miscompares++; $display("[TB] FAIL split64 len: got %0d expected 2", got.len); end
        end
        n++;
      end
    end
    vectors++;
    if (n !== 4) begin miscompares++; $display("[TB] FAIL split64 count: got %0d expected 4", n); end
  endtask

  task automatic test_backpressure;
    bit popped, have; obs_t got, exp, snap;
    cleanState; have = 1'b0; snap = '0;
    for (int i = 0; i < 12; i++) pushInst(($urandom % 2) ? 1 : 2, {$urandom, $urandom});
    padWord;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 1'b0, popped, got, exp);
      if (have) begin
        vectors++;
        if (got !== snap) begin miscompares++; $display("[TB] FAIL stall stable: got %h expected %h", got, snap); end
      end else if (got.dv) begin
        snap = got; have = 1'b1;
      end
    end
    vectors++;
    if (tFr !== 1'b0 || !have) begin miscompares++; $display("[TB] FAIL stall ready: got fr=%b dv=%b expected fr=0 dv=1", tFr, have); end
    for (int c = 0; c < 300 && expQ.size() != 0; c++) begin
      applyStimulus(1'b1, 1'b1, popped, got, exp);
      if (popped) begin
        vectors++;
        if (got !== exp) begin miscompares++; $display("[TB] FAIL stall drain: got %h expected %h", got, exp); end
      end
    end
    vectors++;
    if (expQ.size() !== 0) begin miscompares++; $display("[TB] FAIL stall lost: got %0d left expected 0", expQ.size()); end
  endtask

  task automatic test_readports;
    bit popped; obs_t got, exp; int idx;
    logic [17:0] tbl [6];
    cleanState; idx = 0;
    // {type, unit, op, r1, r2} with rd=15, rs1=0B, rs2=33
    tbl[0] = {1'b1, 3'd6, 2'd2, 6'h0B, 6'h15};
    tbl[1] = {1'b1, 3'd5, 2'd0, 6'h00, 6'h00};
    tbl[2] = {1'b0, 3'd3, 2'd0, 6'h0B, 6'h33};
    tbl[3] = {1'b0, 3'd7, 2'd2, 6'h0B, 6'h00};
    tbl[4] = {1'b1, 3'd7, 2'd1, 6'h0B, 6'h15};
    tbl[5] = {1'b0, 3'd7, 2'd0, 6'h00, 6'h00};
    for (int i = 0; i < 6; i++)
      pushInst(4, {2'b11, tbl[i][17:12], 6'h15, 6'h2A, 6'h0B, 6'h33, 32'($urandom)});
    for (int c = 0; c < 100 && expQ.size() != 0; c++) begin
      applyStimulus(1'b1, 1'b1, popped, got, exp);
      if (popped) begin
        vectors++;
        if (got !== exp) begin miscompares++; $display("[TB] FAIL ports data: got %h expected %h", got, exp); end
        vectors++;
        if ({got.r1, got.r2} !== tbl[idx][11:0]) begin
          miscompares++; $display("[TB] FAIL ports r1/r2 %0d: got %h expected %h", idx, {got.r1, got.r2}, tbl[idx][11:0]);
        end
        idx++;
      end
    end
    vectors++;
    if (idx !== 6) begin miscompares++; $display("[TB] FAIL ports count: got %0d expected 6", idx); end
  endtask

  task automatic test_flush;
    bit popped; obs_t got, exp; int n;
    cleanState; n = 0;
    for (int i = 0; i < 8; i++) pushInst(1, {$urandom, $urandom});
    for (int c = 0; c < 10 && !obs8.dv; c++) applyStimulus(1'b1, 1'b0, popped, got, exp);
    vectors++;
    if (obs8.dv !== 1'b1) begin miscompares++; $display("[TB] FAIL flush setup: got dv=%b expected 1", obs8.dv); end
    decReady = 1'b0; fetchValid = 1'b1; fetchData = 64'h1111_2222_3333_4444; flush = 1'b1;
    @(posedge clk); #1;
    cycle++;
    flush = 1'b0; fetchValid = 1'b0;
    vectors++;
    if ({obs8.dv, obs8.fr} !== 2'b01) begin miscompares++; $display("[TB] FAIL flush state: got %b expected 01", {obs8.dv, obs8.fr}); end
    parcelQ.delete(); expQ.delete();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b1, popped, got, exp);
      if (got.dv) n++;
    end
    vectors++;
    if (n !== 0) begin miscompares++; $display("[TB] FAIL flush leftover: got %0d decodes expected 0", n); end
    for (int i = 0; i < 4; i++) pushInst(1, {$urandom, $urandom});
    for (int c = 0; c < 20 && expQ.size() != 0; c++) begin
      applyStimulus(1'b1, 1'b1, popped, got, exp);
      if (popped) begin
        vectors++;
        if (got !== exp) begin miscompares++; $display("[TB] FAIL flush after: got %h expected %h", got, exp); end
      end
    end
  endtask

  task automatic test_async_reset;
    bit popped; obs_t got, exp, rc; int n;
    cleanState; n = 0; rc = '0; rc.fr = 1'b1;
    for (int i = 0; i < 8; i++) pushInst(($urandom % 2) ? 1 : 2, {$urandom, $urandom});
    padWord;
    for (int c = 0; c < 4; c++) applyStimulus(1'b1, 1'b0, popped, got, exp);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs8 !== rc) begin miscompares++; $display("[TB] FAIL async reset: got %h expected %h", obs8, rc); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    cycle++;
    parcelQ.delete(); expQ.delete();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b1, popped, got, exp);
      if (got.dv) n++;
    end
    vectors++;
    if (n !== 0) begin miscompares++; $display("[TB] FAIL reset leftover: got %0d decodes expected 0", n); end
  endtask

  task automatic test_random16;
    bit popped; obs_t got, exp; int r;
    cleanState; sel16 = 1'b1;
    for (int i = 0; i < 120; i++) begin
      r = $urandom % 3;
      pushInst((r == 0) ? 1 : ((r == 1) ? 2 : 4), {$urandom, $urandom});
    end
    padWord;
    for (int c = 0; c < 5000 && expQ.size() != 0; c++) begin
      applyStimulus(($urandom % 4) != 0, ($urandom % 3) != 0, popped, got, exp);
      if (popped) begin
        vectors++;
        if (got !== exp) begin miscompares++; $display("[TB] FAIL random16: got %h expected %h", got, exp); end
      end
    end
    vectors++;
    if (expQ.size() !== 0) begin miscompares++; $display("[TB] FAIL random16 drain: got %0d left expected 0", expQ.size()); end
    sel16 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; fetchValid = 1'b0; decReady = 1'b0; fetchData = '0;
    #12;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_four16;
    test_split64;
    test_backpressure;
    test_readports;
    test_flush;
    test_async_reset;
    test_random16;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
